// File: rtl/snn_mem_pkg.sv
// Shared types and constants for the synaptic weight RAM arbiter.
package snn_mem_pkg;

  typedef enum logic {ST_INIT, ST_RUN} arb_state_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_HOST, SRC_ENG} grant_src_t;

  // Grant-to-response latency in cycles (RAM read latency is one of them).
  localparam int RSP_LAT = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               req_any
);

  logic found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    req_any = |req;
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/synapse_weight_arbiter.sv
// Shares the single-port weight RAM between NUM_REQ engine readers and the host port.
//   ST_INIT | zero-fill RAM, one word per cycle, no grants
//   ST_RUN  | host priority with burst limit, engines round-robin
module synapse_weight_arbiter
  import snn_mem_pkg::*;
#(
  parameter int NUM_SYNAPSES   = 205,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int NUM_REQ        = 4,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic                      host_valid,
  input  logic                      host_we,
  input  logic [ADDR_W-1:0]         host_addr,
  input  logic [DATA_W-1:0]         host_wdata,
  output logic                      host_ready,
  output logic                      host_rsp_valid,
  output logic [DATA_W-1:0]         host_rdata,
  output logic                      host_err,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      init_done
);

  localparam int IDX_W  = idx_width(NUM_REQ);
  localparam int BC_W   = $clog2(HOST_BURST_MAX + 1);
  localparam int STAGES = RSP_LAT - 1;

  arb_state_t        state, state_nx;
  logic [ADDR_W-1:0] init_cnt, init_cnt_nx;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nx;
  logic [BC_W-1:0]   burst_cnt, burst_cnt_nx;

  logic [NUM_REQ-1:0] eng_gnt;
  logic [IDX_W-1:0]   eng_idx;
  logic               eng_any;
  logic [ADDR_W-1:0]  eng_addr;
  logic               eng_ok, host_ok, host_win;

  grant_src_t        src;
  logic              gnt_err, gnt_we;
  logic              mem_en_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  grant_src_t        pipe_src [STAGES];
  logic [IDX_W-1:0]  pipe_idx [STAGES];
  logic              pipe_err [STAGES];
  logic              pipe_we  [STAGES];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (eng_gnt),
    .idx     (eng_idx),
    .req_any (eng_any)
  );

  assign eng_addr = req_addr[eng_idx*ADDR_W +: ADDR_W];
  assign eng_ok   = ({1'b0, eng_addr}  < (ADDR_W+1)'(NUM_SYNAPSES));
  assign host_ok  = ({1'b0, host_addr} < (ADDR_W+1)'(NUM_SYNAPSES));

  always_comb begin
    state_nx     = state;
    init_cnt_nx  = init_cnt;
    rr_ptr_nx    = rr_ptr;
    burst_cnt_nx = burst_cnt;
    host_win     = 1'b0;
    host_ready   = 1'b0;
    req_ready    = '0;
    src          = SRC_NONE;
    gnt_err      = 1'b0;
    gnt_we       = 1'b0;
    mem_en_c     = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    case (state)
      ST_INIT: begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = init_cnt;
        init_cnt_nx = init_cnt + 1'b1;
        if (init_cnt == ADDR_W'(NUM_SYNAPSES - 1)) begin
          state_nx    = ST_RUN;
          init_cnt_nx = '0;
        end
      end
      ST_RUN: begin
        host_win = host_valid && (!eng_any || (burst_cnt < BC_W'(HOST_BURST_MAX)));
        if (host_win) begin
          host_ready = 1'b1;
          src        = SRC_HOST;
          gnt_we     = host_we;
          gnt_err    = !host_ok;
          if (host_ok) begin
            mem_en_c    = 1'b1;
            mem_we_c    = host_we;
            mem_addr_c  = host_addr;
            mem_wdata_c = host_we ? host_wdata : '0;
          end
          // Burst only counts against the limit while an engine is actually waiting.
          if (!eng_any) burst_cnt_nx = '0;
          else if (burst_cnt != BC_W'(HOST_BURST_MAX)) burst_cnt_nx = burst_cnt + 1'b1;
        end else if (eng_any) begin
          req_ready    = eng_gnt;
          src          = SRC_ENG;
          gnt_err      = !eng_ok;
          mem_en_c     = eng_ok;
          mem_addr_c   = eng_ok ? eng_addr : '0;
          rr_ptr_nx    = (eng_idx == IDX_W'(NUM_REQ - 1)) ? '0 : eng_idx + 1'b1;
          burst_cnt_nx = '0;
        end
      end
      default: ;
    endcase
  end

  // Hold the RAM port quiet while reset is asserted, even though the FSM sits in ST_INIT.
  assign mem_en    = rst_n & mem_en_c;
  assign mem_we    = rst_n & mem_we_c;
  assign mem_addr  = rst_n ? mem_addr_c : '0;
  assign mem_wdata = rst_n ? mem_wdata_c : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      init_cnt  <= init_cnt_nx;
      rr_ptr    <= rr_ptr_nx;
      burst_cnt <= burst_cnt_nx;
      init_done <= (state_nx == ST_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_src[k] <= SRC_NONE;
        pipe_idx[k] <= '0;
        pipe_err[k] <= 1'b0;
        pipe_we[k]  <= 1'b0;
      end
      rsp_valid      <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rdata     <= '0;
      host_err       <= 1'b0;
    end else begin
      pipe_src[0] <= src;
      pipe_idx[0] <= eng_idx;
      pipe_err[0] <= gnt_err;
      pipe_we[0]  <= gnt_we;
      for (int k = 1; k < STAGES; k++) begin
        pipe_src[k] <= pipe_src[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
        pipe_err[k] <= pipe_err[k-1];
        pipe_we[k]  <= pipe_we[k-1];
      end
      rsp_valid      <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rdata     <= '0;
      host_err       <= 1'b0;
      case (pipe_src[STAGES-1])
        SRC_ENG: begin
          rsp_valid <= NUM_REQ'(1) << pipe_idx[STAGES-1];
          rsp_err   <= pipe_err[STAGES-1];
          rsp_data  <= pipe_err[STAGES-1] ? '0 : mem_rdata;
        end
        SRC_HOST: begin
          host_rsp_valid <= 1'b1;
          host_err       <= pipe_err[STAGES-1];
          host_rdata     <= (pipe_err[STAGES-1] || pipe_we[STAGES-1]) ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_weight_arbiter.sv
// Scoreboard bench: driver, reference model and response monitor run as separate processes.
module tb_synapse_weight_arbiter;

  localparam int NS = 205, AW = 8, DW = 16, NR = 4, HB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [DW-1:0]     rsp_data, host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic              rsp_err, host_valid, host_we, host_ready, host_rsp_valid, host_err;
  logic [AW-1:0]     host_addr, mem_addr;
  logic              mem_en, mem_we, init_done;

  always #5 clk = ~clk;

  synapse_weight_arbiter #(
    .NUM_SYNAPSES(NS), .ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR), .HOST_BURST_MAX(HB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rsp_valid(host_rsp_valid), .host_rdata(host_rdata),
    .host_err(host_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_done(init_done)
  );

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] junk(input int a);
    return 16'hA5A5 ^ DW'(a);
  endfunction

  // Environment RAM: synchronous, one-cycle read latency, preloaded with junk.
  logic [DW-1:0] ram [0:255];
  initial begin
    for (int a = 0; a < 256; a++) ram[a] = junk(a);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct { bit host; int idx; logic [DW-1:0] data; bit err; int due; } exp_t;
  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } hcmd_t;

  exp_t          expq[$];
  int            glog[$];
  logic [AW-1:0] eq [NR][$];
  hcmd_t         hq[$];
  bit            run_on = 0, drv_on = 0, drv_rand = 0;
  logic [NR-1:0] acc_eng = '0;
  bit            acc_host = 0;

  // Reference model: decides the grant from the arbitration rules and predicts responses.
  initial begin
    int rr_m, burst_m, w, c;
    bit eng_any, host_w, oor;
    logic [AW-1:0] a;
    logic [NR-1:0] exp_rdy;
    logic [DW-1:0] ref_mem [0:255];
    rr_m = 0; burst_m = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clk);
      acc_eng = '0; acc_host = 0;
      if (!rst_n) begin
        expq.delete();
        rr_m = 0; burst_m = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      end else if (run_on) begin
        eng_any = |req_valid;
        host_w  = host_valid && (!eng_any || burst_m < HB);
        w = -1;
        if (!host_w && eng_any)
          for (int k = 0; k < NR; k++) begin
            c = (rr_m + k) % NR;
            if (w < 0 && req_valid[c]) w = c;
          end
        exp_rdy = (w >= 0) ? NR'(1) << w : '0;
        chk("grant", 64'({host_ready, req_ready}), 64'({host_w, exp_rdy}));
        if (host_ready) glog.push_back(-1);
        for (int i = 0; i < NR; i++) if (req_ready[i]) glog.push_back(i);
        if (host_w) begin
          a = host_addr; oor = (a >= NS);
          chk("host_mem", 64'({mem_en, mem_we, mem_en ? mem_addr : 8'h0, (mem_en && mem_we) ? mem_wdata : 16'h0}),
              64'({!oor, !oor && host_we, oor ? 8'h0 : a, (!oor && host_we) ? host_wdata : 16'h0}));
          expq.push_back('{1, 0, (host_we || oor) ? '0 : ref_mem[a], oor, cyc + 2});
          if (host_we && !oor) ref_mem[a] = host_wdata;
          burst_m = eng_any ? ((burst_m < HB) ? burst_m + 1 : HB) : 0;
          acc_host = 1;
        end else if (w >= 0) begin
          a = req_addr[w*AW +: AW]; oor = (a >= NS);
          chk("eng_mem", 64'({mem_en, mem_we, mem_en ? mem_addr : 8'h0}),
              64'({!oor, 1'b0, oor ? 8'h0 : a}));
          expq.push_back('{0, w, oor ? '0 : ref_mem[a], oor, cyc + 2});
          rr_m = (w + 1) % NR;
          burst_m = 0;
          acc_eng[w] = 1'b1;
        end else begin
          chk("idle_mem", 64'(mem_en), 64'(0));
        end
      end
    end
  end

  // Monitor: pops the scoreboard exactly when a response is due, otherwise requires silence.
  initial begin
    exp_t e;
    logic [38:0] got, want;
    forever begin
      @(negedge clk);
      got = {rsp_valid, rsp_data, rsp_err, host_rsp_valid, host_rdata, host_err};
      if (rst_n && expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        if (e.host) want = {4'b0, 16'h0, 1'b0, 1'b1, e.data, e.err};
        else        want = {NR'(1) << e.idx, e.data, e.err, 1'b0, 16'h0, 1'b0};
        chk(e.host ? "host_rsp" : "eng_rsp", 64'(got), 64'(want));
      end else begin
        chk("rsp_idle", 64'(got), 64'(0));
      end
    end
  end

  // Driver: presents queued commands and holds each until the model says it was granted.
  initial begin
    hcmd_t hc;
    req_valid = '0; req_addr = '0;
    host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        req_valid = '0; host_valid = 0;
        for (int i = 0; i < NR; i++) eq[i].delete();
        hq.delete();
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && acc_eng[i]) req_valid[i] = 1'b0;
          if (drv_on && !req_valid[i] && eq[i].size() > 0 && (!drv_rand || $urandom_range(0, 3) != 0)) begin
            req_addr[i*AW +: AW] = eq[i].pop_front();
            req_valid[i] = 1'b1;
          end
        end
        if (host_valid && acc_host) host_valid = 0;
        if (drv_on && !host_valid && hq.size() > 0 && (!drv_rand || $urandom_range(0, 3) != 0)) begin
          hc = hq.pop_front();
          host_we = hc.we; host_addr = hc.addr; host_wdata = hc.data;
          host_valid = 1;
        end
      end
    end
  end

  task automatic check_reset_vals(input string name);
    chk(name, 64'({mem_en, mem_we, mem_addr, mem_wdata, init_done, req_ready, host_ready, rsp_valid, host_rsp_valid}), 64'(0));
  endtask

  task automatic init_check();
    int good, zeros, keep;
    good = 0;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      if (mem_en && mem_we && mem_addr == AW'(k) && mem_wdata == '0 &&
          req_ready == '0 && !host_ready && !init_done) good++;
    end
    chk("init_writes", 64'(good), 64'(NS));
    @(negedge clk);
    chk("init_done", 64'(init_done), 64'(1));
    zeros = 0; keep = 0;
    for (int a = 0; a < NS; a++) if (ram[a] == '0) zeros++;
    for (int a = NS; a < 256; a++) if (ram[a] == junk(a)) keep++;
    chk("fill_zero", 64'(zeros), 64'(NS));
    chk("fill_bounds", 64'(keep), 64'(256 - NS));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < budget) begin
      @(negedge clk); n++;
      done = (hq.size() == 0) && !host_valid && (req_valid == '0) && (expq.size() == 0);
      for (int i = 0; i < NR; i++) if (eq[i].size() != 0) done = 0;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d cycles want<%0d", n, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic push_random(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NR; i++)
        eq[i].push_back(($urandom_range(0, 4) == 0) ? AW'($urandom_range(200, 255)) : AW'($urandom_range(0, 15)));
      hq.push_back('{bit'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0) ? AW'($urandom_range(200, 255)) : AW'($urandom_range(0, 15)),
                     DW'($urandom)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int rr_exp [5] = '{0, 1, 2, 3, 0};
  int hb_exp [10] = '{-1, -1, -1, -1, 1, -1, -1, -1, -1, 1};

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset_vals");

    // Reset again when init_cnt reaches 100; init must restart from address 0.
    @(posedge clk); #1 rst_n = 1;
    repeat (100) @(negedge clk);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    check_reset_vals("mid_init_reset");
    @(posedge clk); #1 rst_n = 1;
    init_check();
    run_on = 1; drv_on = 1;

    // All engines continuously valid from rr_ptr = 0.
    glog.delete();
    for (int i = 0; i < NR; i++) for (int k = 0; k < 3; k++) eq[i].push_back(AW'(10 + i));
    wait_idle(200);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), 64'(glog.size() > k ? glog[k] : 99), 64'(rr_exp[k]));

    // Host write then engine 2 read-back.
    hq.push_back('{1, 8'd5, 16'hBEEF});
    wait_idle(100);
    eq[2].push_back(8'd5);
    wait_idle(100);
    chk("ram5", 64'(ram[5]), 64'(16'hBEEF));

    // Host and engine 1 continuously valid: burst limit forces interleave.
    glog.delete();
    for (int k = 0; k < 10; k++) hq.push_back('{1, AW'(20 + k), DW'($urandom)});
    for (int k = 0; k < 3; k++) eq[1].push_back(8'd20);
    wait_idle(200);
    for (int k = 0; k < 10; k++) chk($sformatf("burst%0d", k), 64'(glog.size() > k ? glog[k] : 99), 64'(hb_exp[k]));

    // Out-of-range engine read and host write, plus host read at the boundary.
    eq[0].push_back(8'd210);
    hq.push_back('{1, 8'd255, 16'h1234});
    hq.push_back('{0, AW'(NS), 16'h0});
    hq.push_back('{0, AW'(NS - 1), 16'h0});
    wait_idle(100);
    chk("ram255", 64'(ram[255]), 64'(junk(255)));

    drv_rand = 1;
    push_random(60);
    wait_idle(3000);

    // Reset with traffic in flight: scoreboard is discarded, no stale strobes may appear.
    push_random(10);
    repeat (15) @(negedge clk);
    @(posedge clk); #1 rst_n = 0; run_on = 0; drv_on = 0; drv_rand = 0;
    @(negedge clk);
    check_reset_vals("traffic_reset");
    @(posedge clk); #1 rst_n = 1;
    init_check();
    run_on = 1; drv_on = 1;
    eq[0].push_back(8'd5);
    hq.push_back('{0, 8'd21, 16'h0});
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/synapse_weight_arbiter.md
Name: synapse_weight_arbiter

Overview:
- Owns the single-port synaptic weight RAM and shares it between NUM_REQ spike-engine read requesters and one host config port (write/read, fed by the AXI4-Lite front end).
- Zero-fills the RAM after reset.
- Round-robins the engines and gives the host priority, with a starvation guard.
- Returns responses with fixed latency and range checking.

Parameters:
- NUM_SYNAPSES, 205: number of weight words.
- ADDR_W, 8: address width; must satisfy 2**ADDR_W >= NUM_SYNAPSES.
- DATA_W, 16: weight width.
- NUM_REQ, 4: number of engine read requesters.
- HOST_BURST_MAX, 4: maximum consecutive host grants while any engine is pending.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  engine read request, one bit per requester.
- req_addr  in  NUM_REQ*ADDR_W  engine addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  DATA_W  engine read data.
- rsp_err  out  1  engine address out of range.
- host_valid  in  1  host request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  host grant, combinational.
- host_rsp_valid  out  1  host response strobe.
- host_rdata  out  DATA_W  host read data (0 for writes and errors).
- host_err  out  1  host address out of range.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0.
- init_done  out  1  high once zero-fill is complete.

Behaviour:
Reset values:
- Every registered output is 0 during reset: rsp_*, host_rsp_*, mem_*, init_done.
- State = ST_INIT, init_cnt = 0, rr_ptr = 0, burst_cnt = 0.
- An asynchronous reset mid-operation discards in-flight responses and restarts init.

State machine:
- ST_INIT:
  - Each cycle: mem_en=1, mem_we=1, mem_addr=init_cnt, mem_wdata=0, init_cnt+1.
  - After writing NUM_SYNAPSES-1, go to ST_RUN and set init_done=1 on the next cycle.
  - req_ready and host_ready are 0 throughout.
  - Fill takes exactly NUM_SYNAPSES cycles.
- ST_RUN: at most one grant per cycle, chosen as follows.
  - Host wins if host_valid=1 and (no engine valid or burst_cnt < HOST_BURST_MAX).
  - Otherwise, if any engine is valid, the engine wins; winner = first valid index searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - After an engine grant to index i: rr_ptr = (i+1) mod NUM_REQ, burst_cnt = 0.
  - After a host grant: burst_cnt increments (saturating) only if some engine was valid that cycle; otherwise burst_cnt = 0.
  - No grant leaves rr_ptr and burst_cnt unchanged.
- A request is accepted in a cycle where valid and ready are both 1. Requesters hold valid/addr until accepted.

Memory access:
- In-range addresses (addr < NUM_SYNAPSES): the grant drives mem_en=1 combinationally that cycle, with mem_we=host_we for host grants, 0 for engine grants.
- Out-of-range addresses: granted, but mem_en=0.

Response latency (grant in cycle t, response registered in cycle t+2, single-cycle strobe):
- Engine i: rsp_valid[i]=1. rsp_data=mem_rdata, or 0 with rsp_err=1 if out of range.
- Host read: host_rdata=mem_rdata, or 0 with host_err=1 if out of range.
- Host write: host_rdata=0; host_err=1 if out of range (the write is dropped).
- The pipeline is fully pipelined: back-to-back grants give back-to-back responses.
- Responses have no backpressure; consumers must accept them.
- rsp_err/rsp_data and host_err/host_rdata are 0 whenever their strobe is 0.

Read-after-write: a host write in cycle t followed by any read in cycle t+1 returns the new data; this relies on RAM write-before-read ordering across cycles.

Decomposition:
- Package snn_mem_pkg:
  - arb_state_t enum {ST_INIT, ST_RUN}.
  - Constant RSP_LAT=2.
  - Grant-source enum {SRC_NONE, SRC_HOST, SRC_ENG}.
- Sub-module rr_arbiter:
  - Inputs: NUM_REQ request vector and rr_ptr.
  - Outputs: one-hot grant, winner index, any-request flag.
  - Purely combinational.

Test Plan:
- Reset release with NUM_SYNAPSES=205 -> exactly 205 zero writes to addresses 0..204, init_done=1 in cycle 206, no ready asserted before it.
- Host write addr 5 data 0xBEEF, then engine 2 read addr 5 -> rsp_valid=4'b0100 two cycles after grant, rsp_data=0xBEEF, rsp_err=0.
- All 4 engines valid continuously with rr_ptr=0 -> grants in order 0,1,2,3,0; each requester gets one response per 4 cycles.
- Host and engine 1 valid continuously -> grant pattern host×4, engine 1, host×4, ...
- Engine read addr 210, host write addr 255 -> mem_en=0 on both grants; rsp_err=1 with data 0; host_err=1; RAM unchanged.
- rst_n asserted at init_cnt=100, then released -> init restarts at address 0 and completes after 205 cycles; no stale rsp_valid.
